wb_arbiter2: RTL

//  Two-master pipelined Wishbone arbiter feeding the CPU-side slave port of the address-decode MMU.

---
 rtl/wb_arbiter2.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter. It holds the grant for a whole cyc tenure, caps outstanding strobes and recovers from a hung slave with a synthetic ack.
// Optional WB_ARB_ROUND_ROBIN_EN: a collision in IDLE grants the master that was not granted most recently; otherwise datbus always wins.
module wb_arbiter2 #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    // instruction-fetch master
    input  logic        i_ins_cyc,
    input  logic        i_ins_stb,
    input  logic        i_ins_we,
    input  logic [3:0]  i_ins_sel,
    input  logic [31:0] i_ins_adr,
    input  logic [31:0] i_ins_dat,
    output logic [31:0] o_ins_dat,
    output logic        o_ins_ack,
    output logic        o_ins_stall,
    // data master
    input  logic        i_dat_cyc,
    input  logic        i_dat_stb,
    input  logic        i_dat_we,
    input  logic [3:0]  i_dat_sel,
    input  logic [31:0] i_dat_adr,
    input  logic [31:0] i_dat_dat,
    output logic [31:0] o_dat_dat,
    output logic        o_dat_ack,
    output logic        o_dat_stall,
    // merged bus toward the MMU
    output logic        o_cpu_cyc,
    output logic        o_cpu_stb,
    output logic        o_cpu_we,
    output logic [3:0]  o_cpu_sel,
    output logic [31:0] o_cpu_adr,
    output logic [31:0] o_cpu_dat,
    input  logic [31:0] i_cpu_dat,
    input  logic        i_cpu_ack,
    input  logic        i_cpu_stall,
    output logic        fault
);
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, GRANT_INS, GRANT_DAT} state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_out_cnt, w_out_cnt_nxt;
    logic [TMO_W-1:0]   r_tmo_cnt, w_tmo_cnt_nxt;

    logic               w_granted, w_sel_dat, w_full, w_tmo_ack, w_ack_any, w_accept;
    logic               w_m_cyc, w_m_stb, w_m_we, w_oth_cyc, w_dat_wins;
    logic [3:0]         w_m_sel;
    logic [31:0]        w_m_adr, w_m_dat, w_rsp_dat;
    state_t             w_oth_state;

`ifdef WB_ARB_ROUND_ROBIN_EN
    logic r_last_dat;
    assign w_dat_wins = !r_last_dat;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_last_dat <= 1'b0;
        end else if (w_state_nxt != r_state && w_state_nxt != IDLE) begin
            r_last_dat <= (w_state_nxt == GRANT_DAT);
        end
    end
`else
    assign w_dat_wins = 1'b1;
`endif

    assign w_granted   = (r_state != IDLE);
    assign w_sel_dat   = (r_state == GRANT_DAT);
    assign w_m_cyc     = w_sel_dat ? i_dat_cyc : i_ins_cyc;
    assign w_m_stb     = w_sel_dat ? i_dat_stb : i_ins_stb;
    assign w_m_we      = w_sel_dat ? i_dat_we  : i_ins_we;
    assign w_m_sel     = w_sel_dat ? i_dat_sel : i_ins_sel;
    assign w_m_adr     = w_sel_dat ? i_dat_adr : i_ins_adr;
    assign w_m_dat     = w_sel_dat ? i_dat_dat : i_ins_dat;
    assign w_oth_cyc   = w_sel_dat ? i_ins_cyc : i_dat_cyc;
    assign w_oth_state = w_sel_dat ? GRANT_INS : GRANT_DAT;

    assign w_full    = (r_out_cnt == CNT_W'(MAX_OUTSTANDING));
    // A real ack in the expiry cycle takes precedence, so no fault is raised then.
    assign w_tmo_ack = w_granted && (r_out_cnt != '0) && !i_cpu_ack &&
                       (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
    assign w_ack_any = i_cpu_ack | w_tmo_ack;
    assign w_rsp_dat = w_tmo_ack ? 32'h0 : i_cpu_dat;

    assign o_cpu_cyc = w_granted & w_m_cyc;
    assign o_cpu_stb = w_granted & w_m_stb & !w_full;
    assign o_cpu_we  = w_granted & w_m_we;
    assign o_cpu_sel = w_granted ? w_m_sel : 4'h0;
    assign o_cpu_adr = w_granted ? w_m_adr : 32'h0;
    assign o_cpu_dat = w_granted ? w_m_dat : 32'h0;
    assign w_accept  = o_cpu_stb & !i_cpu_stall;

    assign o_ins_ack   = (r_state == GRANT_INS) & w_ack_any;
    assign o_ins_stall = (r_state == GRANT_INS) ? (i_cpu_stall | w_full) : 1'b1;
    assign o_ins_dat   = (r_state == GRANT_INS) ? w_rsp_dat : 32'h0;
    assign o_dat_ack   = (r_state == GRANT_DAT) & w_ack_any;
    assign o_dat_stall = (r_state == GRANT_DAT) ? (i_cpu_stall | w_full) : 1'b1;
    assign o_dat_dat   = (r_state == GRANT_DAT) ? w_rsp_dat : 32'h0;
    assign fault       = w_tmo_ack;

    always_comb begin
        w_state_nxt   = r_state;
        w_out_cnt_nxt = r_out_cnt;
        w_tmo_cnt_nxt = r_tmo_cnt;
        case (r_state)
            IDLE: begin
                w_out_cnt_nxt = '0;
                w_tmo_cnt_nxt = '0;
                if (i_dat_cyc && i_ins_cyc) begin
                    w_state_nxt = w_dat_wins ? GRANT_DAT : GRANT_INS;
                end else if (i_dat_cyc) begin
                    w_state_nxt = GRANT_DAT;
                end else if (i_ins_cyc) begin
                    w_state_nxt = GRANT_INS;
                end
            end
            GRANT_INS, GRANT_DAT: begin
                if (!w_m_cyc) begin
                    // Release: hand straight over to a waiting master, drop the tenure's bookkeeping.
                    w_state_nxt   = w_oth_cyc ? w_oth_state : IDLE;
                    w_out_cnt_nxt = '0;
                    w_tmo_cnt_nxt = '0;
                end else begin
                    if (w_accept && !w_ack_any) begin
                        w_out_cnt_nxt = r_out_cnt + CNT_W'(1);
                    end else if (!w_accept && w_ack_any && r_out_cnt != '0) begin
                        w_out_cnt_nxt = r_out_cnt - CNT_W'(1);
                    end
                    if (w_ack_any || r_out_cnt == '0) begin
                        w_tmo_cnt_nxt = '0;
                    end else begin
                        w_tmo_cnt_nxt = r_tmo_cnt + TMO_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_out_cnt_nxt = '0;
                w_tmo_cnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state   <= IDLE;
            r_out_cnt <= '0;
            r_tmo_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_out_cnt <= w_out_cnt_nxt;
            r_tmo_cnt <= w_tmo_cnt_nxt;
        end
    end

endmodule
